branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 40 ++++
 rtl/bp_sat_counter2.sv | 29 ++
 rtl/branch_predictor.sv | 171 +++++++++++++++++
 tb/tb_branch_predictor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and constants for the direct-mapped branch
//               predictor: table geometry, control-transfer opcodes and the
//               2-bit saturating direction counter encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Default number of direct-mapped table entries (power of two).
  localparam int BP_ENTRIES = 16;

  // Index width for a table of the given size.
  function automatic int bp_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Tag covers PC[31:IDX_W+2]; the two low PC bits are always zero.
  function automatic int bp_tag_w(input int entries);
    return 30 - $clog2(entries);
  endfunction

  localparam int BP_IDX_W = bp_idx_w(BP_ENTRIES);
  localparam int BP_TAG_W = bp_tag_w(BP_ENTRIES);

  // Opcodes of the control transfers that train the predictor.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // 2-bit saturating direction counter; MSB set means predict taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_e;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter2
// Description : Combinational next-state of a 2-bit saturating counter.
//               Moves one step towards ST when taken, towards SNT otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter2
  import bp_pkg::*;
(
  input  ctr2_e cur,
  input  logic  taken,
  output ctr2_e next
);

  // Step the counter, holding at either end of the range.
  always_comb begin
    next = cur;
    case (cur)
      SNT:     next = taken ? WNT : SNT;
      WNT:     next = taken ? WT  : SNT;
      WT:      next = taken ? ST  : WNT;
      ST:      next = taken ? ST  : WT;
      default: next = cur;
    endcase
  end

endmodule : bp_sat_counter2
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit direction
//               counters. Zero-latency lookup for the fetch PC, training and
//               mispredict detection from the execute stage, and saturating
//               resolved/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic        clk,
  input  logic        reset,
  // fetch-stage lookup
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  // execute-stage resolution
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  // statistics
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int IDX_W = bp_idx_w(ENTRIES);
  localparam int TAG_W = bp_tag_w(ENTRIES);

  // Table storage (flop array).
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  ctr2_e             ctr_q    [ENTRIES];

  logic [31:0]       br_count_q, br_count_d;
  logic [31:0]       mp_count_q, mp_count_d;

  // ---------------------------------------------------------------------------
  // Fetch lookup: reads the stored state directly, so an update in the same
  // cycle only becomes visible on the following cycle.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]  if_idx;
  logic [TAG_W-1:0]  if_tag;
  logic              if_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign pred_taken  = if_hit && (ctr_q[if_idx] inside {WT, ST});
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

  // ---------------------------------------------------------------------------
  // Execute-stage resolution
  // ---------------------------------------------------------------------------
  logic              is_branch;
  logic              is_jal;
  logic              upd_qual;
  logic              res_taken;
  logic [IDX_W-1:0]  ex_idx;
  logic [TAG_W-1:0]  ex_tag;
  logic              ex_hit;
  ctr2_e             ctr_cur;
  ctr2_e             ctr_next;

  assign is_branch = (ex_opcode == OPC_BRANCH);
  assign is_jal    = (ex_opcode == OPC_JAL);
  assign upd_qual  = ex_valid && (is_branch || is_jal);
  // A JAL always transfers control whatever the condition unit reports.
  assign res_taken = ex_br_taken || is_jal;

  assign ex_idx  = ex_pc[IDX_W+1:2];
  assign ex_tag  = ex_pc[31:IDX_W+2];
  assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ctr_cur = ctr_q[ex_idx];

  bp_sat_counter2 u_sat_counter (
    .cur   (ctr_cur),
    .taken (res_taken),
    .next  (ctr_next)
  );

  // Decide whether and how the resolving entry is written.
  logic              entry_we_d;
  ctr2_e             entry_ctr_d;
  logic [31:0]       entry_target_d;

  // Hits train the counter (and retarget when taken); taken misses allocate
  // weakly-taken; not-taken misses leave the table alone.
  always_comb begin
    entry_we_d     = 1'b0;
    entry_ctr_d    = ctr_next;
    entry_target_d = target_q[ex_idx];
    if (upd_qual) begin
      if (ex_hit) begin
        entry_we_d  = 1'b1;
        entry_ctr_d = ctr_next;
        if (res_taken) begin
          entry_target_d = ex_target;
        end
      end else if (res_taken) begin
        entry_we_d     = 1'b1;
        entry_ctr_d    = WT;
        entry_target_d = ex_target;
      end
    end
  end

  // Flush when direction differs, or when taken to a different target.
  assign mispredict = upd_qual &&
                      ((res_taken != ex_pred_taken) ||
                       (res_taken && (ex_target != ex_pred_target)));

  assign redirect_pc = mispredict ? (res_taken ? ex_target : (ex_pc + 32'd4))
                                  : 32'd0;

  // Saturating statistics next-state.
  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (upd_qual && (br_count_q != 32'hFFFF_FFFF)) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (mispredict && (mp_count_q != 32'hFFFF_FFFF)) begin
      mp_count_d = mp_count_q + 32'd1;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

  // Table update; reset clears every entry and overrides any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (entry_we_d) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= entry_target_d;
      ctr_q[ex_idx]    <= entry_ctr_d;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_q <= 32'd0;
      mp_count_q <= 32'd0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor. Stimulus pushes the
//               expected combinational outputs into a queue; a negedge monitor
//               pops and compares. Expectations come from a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int         NENT = 16;
  localparam int         NIDX = 4;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc = 32'd0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [6:0]  ex_opcode = 7'd0;
  logic [31:0] ex_pc = 32'd0;
  logic        ex_br_taken = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = 32'd0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(NENT)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_pc          (ex_pc),
    .ex_br_taken    (ex_br_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  typedef struct packed {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic        chk_rd;
    logic [31:0] rd;
    logic [31:0] brc;
    logic [31:0] mpc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference table: plain arrays, counter held as an integer 0..3.
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  bit [31:0]   m_tgt   [NENT];
  int          m_ctr   [NENT];
  bit [31:0]   m_br;
  bit [31:0]   m_mp;

  task automatic m_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
    end
    m_br = 32'd0; m_mp = 32'd0;
  endtask

  task automatic m_predict(input bit [31:0] pc, output bit t, output bit [31:0] tgt);
    int          idx;
    int unsigned tg;
    idx = int'((pc >> 2) % NENT);
    tg  = pc >> (NIDX + 2);
    t   = m_valid[idx] && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
    tgt = t ? m_tgt[idx] : pc + 32'd4;
  endtask

  // Drive one cycle, record expectations, then advance the model past the edge.
  task automatic cycle(input bit rst, input bit [31:0] ipc, input bit v,
                       input bit [6:0] opc, input bit [31:0] epc, input bit bt,
                       input bit [31:0] etgt, input bit ept, input bit [31:0] eptgt);
    exp_t        e;
    bit          t;
    bit [31:0]   tgt;
    bit          qual, tk, hit;
    int          idx;
    int unsigned tg;
    reset = rst; if_pc = ipc; ex_valid = v; ex_opcode = opc; ex_pc = epc;
    ex_br_taken = bt; ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
    m_predict(ipc, t, tgt);
    qual     = v && (opc == BR || opc == JAL);
    tk       = bt || (opc == JAL);
    e.pt     = t;
    e.ptgt   = tgt;
    e.mp     = qual && ((tk != ept) || (tk && etgt != eptgt));
    e.chk_rd = e.mp || !v;
    e.rd     = !v ? 32'd0 : (tk ? etgt : epc + 32'd4);
    e.brc    = m_br;
    e.mpc    = m_mp;
    sb.push_back(e);
    if (rst) begin
      m_reset();
    end else if (qual) begin
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (e.mp && m_mp != 32'hFFFF_FFFF) m_mp++;
      idx = int'((epc >> 2) % NENT);
      tg  = epc >> (NIDX + 2);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      if (hit) begin
        m_ctr[idx] = tk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                        : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        if (tk) m_tgt[idx] = etgt;
      end else if (tk) begin
        m_valid[idx] = 1'b1; m_tag[idx] = tg; m_tgt[idx] = etgt; m_ctr[idx] = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit [31:0] ipc);
    cycle(1'b0, ipc, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: outputs are combinational, compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e.pt});
      chk("pred_target", pred_target,         e.ptgt);
      chk("mispredict",  {31'd0, mispredict}, {31'd0, e.mp});
      if (e.chk_rd) chk("redirect_pc", redirect_pc, e.rd);
      chk("br_count",    br_count,            e.brc);
      chk("mp_count",    mp_count,            e.mpc);
    end
  end

  function automatic bit [31:0] rand_pc();
    return (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    bit [31:0] epc, ipc, etgt, ptgt;
    bit        pt, v, bt, rst;
    bit [6:0]  opc;
    m_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed scenarios.
    idle(32'h100);
    cycle(0, 32'h100, 1, BR, 32'h100, 1, 32'h80, 0, 32'h104);  // allocate, no bypass
    idle(32'h100);                                             // now predicts 0x80
    cycle(0, 32'h100, 1, BR, 32'h100, 0, 32'h80, 1, 32'h80);   // 10 -> 01, mispredict
    cycle(0, 32'h100, 1, BR, 32'h100, 0, 32'h80, 0, 32'h104);  // 01 -> 00, correct
    idle(32'h100);
    cycle(0, 32'h100, 1, BR, 32'h100, 1, 32'h80, 0, 32'h104);  // 00 -> 01
    cycle(0, 32'h100, 1, BR, 32'h140, 1, 32'h200, 0, 32'h144); // alias replaces
    idle(32'h100);
    idle(32'h140);
    cycle(0, 32'h40, 1, JAL, 32'h40, 0, 32'h400, 0, 32'h44);   // JAL forced taken
    idle(32'h40);
    cycle(0, 32'h40, 1, ALU, 32'h40, 1, 32'h990, 0, 32'h44);   // ignored opcode
    idle(32'h40);
    cycle(1, 32'h40, 1, BR, 32'h40, 1, 32'h500, 0, 32'h44);    // reset wins
    idle(32'h40);
    idle(32'h140);

    // Randomised traffic over a small PC pool so entries hit and alias.
    for (int n = 0; n < 600; n++) begin
      epc  = rand_pc();
      ipc  = ($urandom_range(0, 1) == 0) ? epc : rand_pc();
      v    = ($urandom_range(0, 99) < 85);
      rst  = ($urandom_range(0, 59) == 0);
      bt   = $urandom_range(0, 1) == 1;
      etgt = 32'($urandom_range(0, 7)) << 4;
      case ($urandom_range(0, 3))
        0, 1:    opc = BR;
        2:       opc = JAL;
        default: opc = ($urandom_range(0, 1) == 0) ? ALU : 7'h13;
      endcase
      if ($urandom_range(0, 1) == 0) begin
        m_predict(epc, pt, ptgt);
      end else begin
        pt   = $urandom_range(0, 1) == 1;
        ptgt = 32'($urandom_range(0, 7)) << 4;
      end
      cycle(rst, ipc, v, opc, epc, bt, etgt, pt, ptgt);
    end
    idle(32'h0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_branch_predictor
`default_nettype wire
